// File: rtl/uart_frame_pkg.sv
// Shared types, error codes and the CRC-8 step for the UART frame receiver.
package uart_frame_pkg;

    localparam int unsigned ERR_W = 3;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC,
        ST_TAIL
    } frame_state_e;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_FRAMING = 3'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd2;
    localparam logic [ERR_W-1:0] ERR_TAIL    = 3'd3;
    localparam logic [ERR_W-1:0] ERR_CRC     = 3'd4;

    // One byte of CRC-8, polynomial 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_frame_if.sv
// Result bus from the frame receiver to the control decode.
interface uart_frame_if #(
    parameter int unsigned PAYLOAD_LEN = 12
) ();
    import uart_frame_pkg::*;

    logic [PAYLOAD_LEN*8-1:0] payload;
    logic                     frame_valid;
    logic                     frame_err;
    logic [ERR_W-1:0]         err_code;
    logic                     busy;
    logic [CNT_W-1:0]         frame_cnt;
    logic [CNT_W-1:0]         err_cnt;

    modport master (
        output payload, frame_valid, frame_err, err_code, busy, frame_cnt, err_cnt
    );

    modport slave (
        input payload, frame_valid, frame_err, err_code, busy, frame_cnt, err_cnt
    );

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop sync, start-glitch reject, 3-tap majority per bit.
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       byte_ferr
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned CNT_W   = $clog2(BPS_CNT);
    localparam int unsigned MID     = BPS_CNT / 2;

    logic             rxd_s1, rxd_s2, rxd_s3;
    logic             active_q;
    logic [3:0]       bit_idx_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic             tap0_q, tap1_q;
    logic [7:0]       shreg_q;
    logic             vote_c;

    assign vote_c    = (tap0_q & tap1_q) | (tap0_q & rxd_s2) | (tap1_q & rxd_s2);
    assign byte_data = shreg_q;

    // Synchroniser plus one extra stage for falling-edge detection; idles high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    // Bit timing, sampling and byte assembly; disarms right after the stop sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            active_q  <= 1'b0;
            bit_idx_q <= '0;
            clk_cnt_q <= '0;
            tap0_q    <= 1'b1;
            tap1_q    <= 1'b1;
            shreg_q   <= '0;
            byte_done <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!active_q) begin
                if (rxd_s3 && !rxd_s2) begin
                    active_q  <= 1'b1;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                end
            end else begin
                if (clk_cnt_q == CNT_W'(BPS_CNT - 1)) begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= bit_idx_q + 4'd1;
                end else begin
                    clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                end
                if (clk_cnt_q == CNT_W'(MID - 1)) tap0_q <= rxd_s2;
                if (clk_cnt_q == CNT_W'(MID))     tap1_q <= rxd_s2;
                if (bit_idx_q == 4'd0 && clk_cnt_q == CNT_W'(MID) && rxd_s2) begin
                    active_q <= 1'b0;
                end
                if (bit_idx_q != 4'd0 && clk_cnt_q == CNT_W'(MID + 1)) begin
                    if (bit_idx_q == 4'd9) begin
                        byte_done <= 1'b1;
                        byte_ferr <= ~vote_c;
                        active_q  <= 1'b0;
                    end else begin
                        shreg_q <= {vote_c, shreg_q[7:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler: HEAD, payload, optional CRC-8, TAIL; coded errors and timeout.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned UART_BPS     = 115200,
    parameter int unsigned PAYLOAD_LEN  = 12,
    parameter logic [7:0]  HEAD_BYTE    = 8'h55,
    parameter logic [7:0]  TAIL_BYTE    = 8'hAA,
    parameter bit          CRC_EN       = 1'b1,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          uart_rxd,
    uart_frame_if.master  frm
);

    localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
    localparam int unsigned IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int unsigned PL_W     = PAYLOAD_LEN * 8;

    logic             byte_done;
    logic [7:0]       byte_data;
    logic             byte_ferr;

    frame_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       crc_q, crc_d;
    logic [PL_W-1:0]  shadow_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             store_c, good_c, err_c;
    logic [ERR_W-1:0] code_c;

    logic [PL_W-1:0]  payload_q;
    logic             frame_valid_q, frame_err_q, busy_q;
    logic [ERR_W-1:0] err_code_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_byte_rx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .byte_done (byte_done),
        .byte_data (byte_data),
        .byte_ferr (byte_ferr)
    );

    assign frm.payload     = payload_q;
    assign frm.frame_valid = frame_valid_q;
    assign frm.frame_err   = frame_err_q;
    assign frm.err_code    = err_code_q;
    assign frm.busy        = busy_q;
    assign frm.frame_cnt   = frame_cnt_q;
    assign frm.err_cnt     = err_cnt_q;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next state and per-byte decisions; a byte takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        store_c = 1'b0;
        good_c  = 1'b0;
        err_c   = 1'b0;
        code_c  = ERR_NONE;
        if (state_q == ST_IDLE) begin
            if (byte_done && !byte_ferr && byte_data == HEAD_BYTE) begin
                state_d = ST_PAYLOAD;
                idx_d   = '0;
                crc_d   = '0;
            end
        end else if (byte_done) begin
            if (byte_ferr) begin
                err_c   = 1'b1;
                code_c  = ERR_FRAMING;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_PAYLOAD: begin
                        store_c = 1'b1;
                        crc_d   = crc8_byte(crc_q, byte_data);
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
                            state_d = CRC_EN ? ST_CRC : ST_TAIL;
                        end
                    end
                    ST_CRC: begin
                        if (byte_data != crc_q) begin
                            err_c   = 1'b1;
                            code_c  = ERR_CRC;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        state_d = ST_IDLE;
                        if (byte_data == TAIL_BYTE) begin
                            good_c = 1'b1;
                        end else begin
                            err_c  = 1'b1;
                            code_c = ERR_TAIL;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
            err_c   = 1'b1;
            code_c  = ERR_TIMEOUT;
            state_d = ST_IDLE;
        end
    end

    // Shadow payload, running CRC, index and inter-byte idle counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q    <= '0;
            crc_q    <= '0;
            shadow_q <= '0;
            to_cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            crc_q <= crc_d;
            if (store_c) begin
                for (int i = 0; i < int'(PAYLOAD_LEN); i++) begin
                    if (idx_q == IDX_W'(i)) shadow_q[i*8 +: 8] <= byte_data;
                end
            end
            if (state_q == ST_IDLE || byte_done) to_cnt_q <= '0;
            else                                 to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Registered results: strobes, visible payload, error code, busy and counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            frame_valid_q <= good_c;
            frame_err_q   <= err_c;
            busy_q        <= (state_d != ST_IDLE);
            if (good_c) begin
                payload_q <= shadow_q;
                if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (err_c) begin
                err_code_q <= code_c;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomised scoreboard bench for uart_frame_rx: frame model in the stimulus, monitors pop and compare.
module tb_uart_frame_rx;

    localparam int unsigned CLK_F   = 1_600_000;
    localparam int unsigned BAUD    = 100_000;
    localparam int unsigned BPS     = CLK_F / BAUD;
    localparam int unsigned TO_BITS = 20;
    localparam int unsigned PLEN    = 12;

    typedef struct {
        bit          is_err;
        logic [2:0]  code;
        logic [95:0] pl;
        logic [15:0] cnt;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic rxd_a, rxd_b;

    int n_checks = 0;
    int n_fail   = 0;
    int bd_cnt_a = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a, e_b;
    logic [95:0] last_pl_a;
    logic [15:0] exp_fc_a, exp_ec_a;
    logic [15:0] exp_fc_b;

    uart_frame_if #(.PAYLOAD_LEN(PLEN)) ifa ();
    uart_frame_if #(.PAYLOAD_LEN(1))    ifb ();

    uart_frame_rx #(
        .CLK_FREQ(CLK_F), .UART_BPS(BAUD), .PAYLOAD_LEN(PLEN),
        .HEAD_BYTE(8'h55), .TAIL_BYTE(8'hAA), .CRC_EN(1'b1), .TIMEOUT_BITS(TO_BITS)
    ) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_a), .frm(ifa)
    );

    uart_frame_rx #(
        .CLK_FREQ(CLK_F), .UART_BPS(BAUD), .PAYLOAD_LEN(1),
        .HEAD_BYTE(8'h55), .TAIL_BYTE(8'hAA), .CRC_EN(1'b0), .TIMEOUT_BITS(TO_BITS)
    ) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_b), .frm(ifb)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-8: serial LFSR over the payload bits, MSB of each byte first.
    function automatic logic [7:0] ref_crc(input logic [95:0] pl, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ pl[i*8 + j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic push_good_a(input logic [95:0] pl);
        exp_t e;
        exp_fc_a  = exp_fc_a + 16'd1;
        last_pl_a = pl;
        e.is_err = 1'b0; e.code = 3'd0; e.pl = pl; e.cnt = exp_fc_a;
        q_a.push_back(e);
    endtask

    task automatic push_err_a(input logic [2:0] code);
        exp_t e;
        exp_ec_a = exp_ec_a + 16'd1;
        e.is_err = 1'b1; e.code = code; e.pl = last_pl_a; e.cnt = exp_ec_a;
        q_a.push_back(e);
    endtask

    task automatic score(input string tag, input exp_t e, input logic v, input logic [2:0] code,
                         input logic [95:0] pl, input logic [15:0] fc, input logic [15:0] ec,
                         input logic busy);
        check({tag, "_kind_valid"}, 128'(v), 128'(!e.is_err));
        if (e.is_err) begin
            check({tag, "_err_code"}, 128'(code), 128'(e.code));
            check({tag, "_err_cnt"}, 128'(ec), 128'(e.cnt));
        end else begin
            check({tag, "_frame_cnt"}, 128'(fc), 128'(e.cnt));
        end
        check({tag, "_payload"}, 128'(pl), 128'(e.pl));
        check({tag, "_busy_at_strobe"}, 128'(busy), 128'(0));
    endtask

    // Monitor A: every result strobe must match the oldest expected event.
    always @(negedge sys_clk) begin
        if (sys_rst_n && (ifa.frame_valid || ifa.frame_err)) begin
            check("a_strobe_exclusive", 128'(ifa.frame_valid & ifa.frame_err), 128'(0));
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_strobe: valid=%0b err=%0b code=%0d, expected no event",
                         ifa.frame_valid, ifa.frame_err, ifa.err_code);
            end else begin
                e_a = q_a.pop_front();
                score("a", e_a, ifa.frame_valid, ifa.err_code, ifa.payload,
                      ifa.frame_cnt, ifa.err_cnt, ifa.busy);
            end
        end
        if (u_dut_a.byte_done) bd_cnt_a++;
    end

    // Monitor B: single-byte payload, no CRC.
    always @(negedge sys_clk) begin
        if (sys_rst_n && (ifb.frame_valid || ifb.frame_err)) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_strobe: valid=%0b err=%0b, expected no event",
                         ifb.frame_valid, ifb.frame_err);
            end else begin
                e_b = q_b.pop_front();
                score("b", e_b, ifb.frame_valid, ifb.err_code, 96'(ifb.payload),
                      ifb.frame_cnt, ifb.err_cnt, ifb.busy);
            end
        end
    end

    task automatic idle_bits(input int n);
        repeat (n * BPS) @(negedge sys_clk);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel) rxd_b = bits[i];
            else     rxd_a = bits[i];
            repeat (BPS) @(negedge sys_clk);
        end
        if (sel) rxd_b = 1'b1;
        else     rxd_a = 1'b1;
    endtask

    // mode: 0 good, 1 bad CRC, 2 bad tail, 3 framing error at byte 'where', 4 stall before byte 'where'.
    task automatic send_frame_a(input int mode, input int where, input bit seq);
        logic [95:0] pl;
        logic [7:0]  crc, t;
        for (int i = 0; i < int'(PLEN); i++) begin
            pl[i*8 +: 8] = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
        end
        crc = ref_crc(pl, PLEN);
        send_byte(1'b0, 8'h55, 1'b1);
        check("a_busy_in_frame", 128'(ifa.busy), 128'(1));
        for (int i = 0; i < int'(PLEN); i++) begin
            if (mode == 4 && i == where) begin
                push_err_a(3'd2);
                idle_bits(TO_BITS + 6);
                return;
            end
            if (mode == 3 && i == where) begin
                push_err_a(3'd1);
                send_byte(1'b0, pl[i*8 +: 8], 1'b0);
                idle_bits(2);
                return;
            end
            send_byte(1'b0, pl[i*8 +: 8], 1'b1);
        end
        if (mode == 1) begin
            push_err_a(3'd4);
            send_byte(1'b0, crc ^ 8'h01, 1'b1);
            send_byte(1'b0, 8'hAA, 1'b1);
            idle_bits(2);
            return;
        end
        send_byte(1'b0, crc, 1'b1);
        if (mode == 2) begin
            t = (where == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if (t == 8'hAA) t = 8'h00;
            push_err_a(3'd3);
            send_byte(1'b0, t, 1'b1);
            idle_bits(2);
            return;
        end
        push_good_a(pl);
        send_byte(1'b0, 8'hAA, 1'b1);
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 40 * int'(BPS); i++) begin
            if ((sel ? q_b.size() : q_a.size()) == 0) break;
            @(negedge sys_clk);
        end
        check(sel ? "b_pending_events" : "a_pending_events",
              128'(sel ? q_b.size() : q_a.size()), 128'(0));
    endtask

    task automatic check_reset_a();
        check("rst_payload",     128'(ifa.payload),     128'(0));
        check("rst_frame_valid", 128'(ifa.frame_valid), 128'(0));
        check("rst_frame_err",   128'(ifa.frame_err),   128'(0));
        check("rst_err_code",    128'(ifa.err_code),    128'(0));
        check("rst_busy",        128'(ifa.busy),        128'(0));
        check("rst_frame_cnt",   128'(ifa.frame_cnt),   128'(0));
        check("rst_err_cnt",     128'(ifa.err_cnt),     128'(0));
    endtask

    initial begin
        int         bd0;
        logic [7:0] g;
        exp_t       eb;
        sys_rst_n = 1'b0;
        rxd_a     = 1'b1;
        rxd_b     = 1'b1;
        last_pl_a = '0;
        exp_fc_a  = '0;
        exp_ec_a  = '0;
        exp_fc_b  = '0;
        repeat (5) @(negedge sys_clk);
        check_reset_a();
        sys_rst_n = 1'b1;
        idle_bits(1);

        // Directed pass over each frame outcome.
        send_frame_a(0, 0, 1'b1);
        idle_bits(2);
        check("a_payload_byte0",  128'(ifa.payload[7:0]),   128'(8'h01));
        check("a_payload_byte11", 128'(ifa.payload[95:88]), 128'(8'h0C));
        check("a_busy_after",     128'(ifa.busy),           128'(0));
        send_frame_a(1, 0, 1'b1);
        send_frame_a(2, 0, 1'b1);
        send_frame_a(4, 2, 1'b0);
        send_frame_a(0, 0, 1'b0);
        idle_bits(2);
        send_frame_a(3, 5, 1'b0);

        // Short low pulse while idle must not produce a byte.
        bd0   = bd_cnt_a;
        rxd_a = 1'b0;
        repeat (5) @(negedge sys_clk);
        rxd_a = 1'b1;
        idle_bits(3);
        check("glitch_no_byte", 128'(bd_cnt_a - bd0), 128'(0));
        check("glitch_err_cnt", 128'(ifa.err_cnt), 128'(exp_ec_a));

        // Garbage before a head is dropped; then two frames with no gap.
        send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b0, 8'hFF, 1'b1);
        send_byte(1'b0, 8'h12, 1'b1);
        g = 8'($urandom_range(0, 255));
        if (g == 8'h55) g = 8'h56;
        send_byte(1'b0, g, 1'b1);
        send_frame_a(0, 0, 1'b0);
        send_frame_a(0, 0, 1'b0);
        idle_bits(2);

        // Random mix of outcomes.
        for (int k = 0; k < 8; k++) begin
            send_frame_a(int'($urandom_range(0, 4)), int'($urandom_range(0, PLEN - 1)), 1'b0);
            idle_bits(2);
        end
        drain(1'b0);
        check("a_total_frames", 128'(ifa.frame_cnt), 128'(exp_fc_a));
        check("a_total_errors", 128'(ifa.err_cnt),   128'(exp_ec_a));

        // Reset in the middle of a payload.
        send_byte(1'b0, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(1'b0, 8'($urandom_range(0, 255)), 1'b1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_a();
        last_pl_a = '0;
        exp_fc_a  = '0;
        exp_ec_a  = '0;
        sys_rst_n = 1'b1;
        idle_bits(TO_BITS + 4);
        check("a_busy_after_reset", 128'(ifa.busy), 128'(0));
        send_frame_a(0, 0, 1'b0);
        idle_bits(2);
        drain(1'b0);

        // Single-byte payload without CRC.
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 8'h7E : 8'($urandom_range(0, 255));
            exp_fc_b = exp_fc_b + 16'd1;
            eb.is_err = 1'b0; eb.code = 3'd0; eb.pl = 96'(g); eb.cnt = exp_fc_b;
            send_byte(1'b1, 8'h55, 1'b1);
            send_byte(1'b1, g, 1'b1);
            q_b.push_back(eb);
            send_byte(1'b1, 8'hAA, 1'b1);
            idle_bits(2);
            if (k == 0) check("b_payload_7e", 128'(ifb.payload), 128'(8'h7E));
        end
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
